mac_array_sequencer: RTL and testbench

- Host-side command engine for the systolic MAC array top level.
- Accepts one command at a time and converts it into single-cycle start pulses, a mode value and a clear pulse.
- Monitors busy, captures each lane's accumulator on the rising edge of its valid bit, then streams the captured results out over a valid/ready port.
- Replaces hand-sequenced stimulus and capture logic with synthesizable control.

---
 rtl/mac_array_sequencer_if.sv | 41 ++++
 rtl/mac_array_sequencer.sv | 172 +++++++++++++++++
 tb/tb_mac_array_sequencer.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_array_sequencer_if.sv
// Host command, array control and result stream bundle for mac_array_sequencer.
// master = sequencer side, slave = host/array side.
interface mac_array_sequencer_if #(
  parameter int ACC_W  = 16,
  parameter int N_MACS = 4
);
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [1:0]               cmd_op;
  logic [2:0]               cmd_mode;
  logic                     start_weight;
  logic                     start_valid_pipeline;
  logic                     start_layering;
  logic [2:0]               mode;
  logic                     clear_all;
  logic                     busy;
  logic [N_MACS*ACC_W-1:0]  acc_in;
  logic [N_MACS-1:0]        valid_out;
  logic                     res_valid;
  logic                     res_ready;
  logic signed [ACC_W-1:0]  res_data;
  logic [3:0]               res_idx;
  logic                     res_last;
  logic [N_MACS-1:0]        cap_mask;
  logic                     done;
  logic                     err_timeout;

  modport master (
    input  cmd_valid, cmd_op, cmd_mode, busy, acc_in, valid_out, res_ready,
    output cmd_ready, start_weight, start_valid_pipeline, start_layering, mode,
           clear_all, res_valid, res_data, res_idx, res_last, cap_mask, done,
           err_timeout
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_mode, busy, acc_in, valid_out, res_ready,
    input  cmd_ready, start_weight, start_valid_pipeline, start_layering, mode,
           clear_all, res_valid, res_data, res_idx, res_last, cap_mask, done,
           err_timeout
  );
endinterface

// File: rtl/mac_array_sequencer.sv
// MAC array command sequencer: start pulse 1 cycle after accept, clear done at T+2.
// Captures lane accumulators on valid rising edges; result stream holds while res_ready is low.
module mac_array_sequencer #(
  parameter int ACC_W     = 16,
  parameter int N_MACS    = 4,
  parameter int BUSY_WAIT = 8,
  parameter int TIMEOUT   = 500
) (
  input logic                   clk,
  input logic                   rst,
  mac_array_sequencer_if.master bus
);
  localparam int CNT_MAX = (TIMEOUT > BUSY_WAIT) ? TIMEOUT : BUSY_WAIT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] L_BW_LAST = CNT_W'(BUSY_WAIT - 1);
  localparam logic [CNT_W-1:0] L_TO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_BUSY, S_RUN, S_DRAIN, S_DONE
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic [1:0]              r_op;
  logic [CNT_W-1:0]        r_cnt;
  logic [N_MACS-1:0]       r_valid_prev, r_cap_mask, r_rem;
  logic signed [ACC_W-1:0] r_cap [N_MACS];

  logic                    r_cmd_ready, r_start_w, r_start_vp, r_start_l, r_clear;
  logic [2:0]              r_mode;
  logic                    r_res_valid, r_res_last, r_done, r_err;
  logic signed [ACC_W-1:0] r_res_data;
  logic [3:0]              r_res_idx;

  logic                    w_accept, w_take, w_any, w_err_set, w_clr_op;
  logic [N_MACS-1:0]       w_rise, w_mask_nxt, w_lo_hot;
  logic [3:0]              w_lo;
  logic signed [ACC_W-1:0] w_lo_dat;

  assign w_accept   = bus.cmd_valid & r_cmd_ready;
  assign w_clr_op   = (r_state == S_ISSUE) && (r_op == 2'b11);
  assign w_rise     = ((r_state == S_WAIT_BUSY) || (r_state == S_RUN)) ?
                      (bus.valid_out & ~r_valid_prev) : '0;
  assign w_mask_nxt = r_cap_mask | w_rise;
  assign w_any      = |r_rem;
  assign w_take     = (r_state == S_DRAIN) && (!r_res_valid || bus.res_ready);

  // Lowest remaining lane is the next beat; the descending loop leaves the lowest hit.
  always_comb begin
    w_lo     = '0;
    w_lo_hot = '0;
    w_lo_dat = '0;
    for (int i = N_MACS - 1; i >= 0; i--) begin
      if (r_rem[i]) begin
        w_lo        = 4'(i);
        w_lo_hot    = '0;
        w_lo_hot[i] = 1'b1;
        w_lo_dat    = r_cap[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_err_set   = 1'b0;
    case (r_state)
      S_IDLE:      if (w_accept) w_state_nxt = S_ISSUE;
      S_ISSUE:     w_state_nxt = (r_op == 2'b11) ? S_DONE : S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (bus.busy) begin
          w_state_nxt = S_RUN;
        end else if (r_cnt == L_BW_LAST) begin
          // A weight load may finish before busy is ever seen.
          w_state_nxt = S_DRAIN;
          w_err_set   = (r_op != 2'b00);
        end
      end
      S_RUN: begin
        if (!bus.busy) begin
          w_state_nxt = S_DRAIN;
        end else if (r_cnt == L_TO_LAST) begin
          w_state_nxt = S_DRAIN;
          w_err_set   = 1'b1;
        end
      end
      S_DRAIN:     if (w_take && !w_any) w_state_nxt = S_DONE;
      S_DONE:      w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op         <= '0;
      r_cnt        <= '0;
      r_valid_prev <= '0;
      r_cap_mask   <= '0;
      r_rem        <= '0;
      r_cmd_ready  <= 1'b0;
      r_start_w    <= 1'b0;
      r_start_vp   <= 1'b0;
      r_start_l    <= 1'b0;
      r_clear      <= 1'b0;
      r_mode       <= '0;
      r_res_valid  <= 1'b0;
      r_res_data   <= '0;
      r_res_idx    <= '0;
      r_res_last   <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_valid_prev <= bus.valid_out;
      r_cnt        <= (w_state_nxt != r_state) ? '0 : r_cnt + 1'b1;
      r_cmd_ready  <= (w_state_nxt == S_IDLE);
      r_start_w    <= w_accept && (bus.cmd_op == 2'b00);
      r_start_vp   <= w_accept && (bus.cmd_op == 2'b01);
      r_start_l    <= w_accept && (bus.cmd_op == 2'b10);
      r_clear      <= w_accept && (bus.cmd_op == 2'b11);
      r_done       <= (w_state_nxt == S_DONE);
      if (w_accept) begin
        r_op   <= bus.cmd_op;
        r_mode <= bus.cmd_mode;
      end
      if (w_accept || w_clr_op) r_cap_mask <= '0;
      else                      r_cap_mask <= w_mask_nxt;
      if (w_accept)       r_err <= 1'b0;
      else if (w_err_set) r_err <= 1'b1;
      if (r_state != S_DRAIN && w_state_nxt == S_DRAIN) begin
        r_rem <= w_mask_nxt;
      end else if (w_take && w_any) begin
        r_rem <= r_rem & ~w_lo_hot;
      end
      if (w_take) begin
        r_res_valid <= w_any;
        if (w_any) begin
          r_res_data <= w_lo_dat;
          r_res_idx  <= w_lo;
          r_res_last <= ((r_rem & ~w_lo_hot) == '0);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_MACS; i++) r_cap[i] <= '0;
    end else if (w_clr_op) begin
      for (int i = 0; i < N_MACS; i++) r_cap[i] <= '0;
    end else begin
      for (int i = 0; i < N_MACS; i++)
        if (w_rise[i]) r_cap[i] <= bus.acc_in[i*ACC_W +: ACC_W];
    end
  end

  assign bus.cmd_ready            = r_cmd_ready;
  assign bus.start_weight         = r_start_w;
  assign bus.start_valid_pipeline = r_start_vp;
  assign bus.start_layering       = r_start_l;
  assign bus.mode                 = r_mode;
  assign bus.clear_all            = r_clear;
  assign bus.res_valid            = r_res_valid;
  assign bus.res_data             = r_res_data;
  assign bus.res_idx              = r_res_idx;
  assign bus.res_last             = r_res_last;
  assign bus.cap_mask             = r_cap_mask;
  assign bus.done                 = r_done;
  assign bus.err_timeout          = r_err;
endmodule

// File: tb/tb_mac_array_sequencer.sv
// Scoreboard bench for mac_array_sequencer: expected result beats are queued as
// lane stimulus is driven and popped when the DUT hands a beat over.
module tb_mac_array_sequencer;
  localparam int ACC_W     = 16;
  localparam int N_MACS    = 4;
  localparam int BUSY_WAIT = 8;
  localparam int TIMEOUT   = 500;

  typedef struct {
    int data;
    int idx;
    int last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_beats  = 0;
  beat_t sb[$];

  mac_array_sequencer_if #(.ACC_W(ACC_W), .N_MACS(N_MACS)) bus ();

  mac_array_sequencer #(
    .ACC_W(ACC_W), .N_MACS(N_MACS), .BUSY_WAIT(BUSY_WAIT), .TIMEOUT(TIMEOUT)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input int v);
    bus.acc_in[i*ACC_W +: ACC_W] = ACC_W'(v);
    bus.valid_out[i] = 1'b1;
  endtask

  task automatic push_exp(input int d, input int i, input int l);
    beat_t b;
    b.data = d;
    b.idx  = i;
    b.last = l;
    sb.push_back(b);
  endtask

  // Returns in cycle T+1 (one cycle after the accepting edge).
  task automatic send_cmd(input logic [1:0] op, input logic [2:0] md);
    int n = 0;
    while (!bus.cmd_ready && n < 20) begin
      tick();
      n++;
    end
    check("cmd_ready_wait", int'(bus.cmd_ready), 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_mode  = md;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max);
    int n = 0;
    while (!bus.done && n < max) begin
      tick();
      n++;
    end
    check(tag, int'(bus.done), 1);
  endtask

  function automatic int outs_or();
    return int'(|{bus.cmd_ready, bus.start_weight, bus.start_valid_pipeline,
                  bus.start_layering, bus.mode, bus.clear_all, bus.res_valid,
                  bus.res_data, bus.res_idx, bus.res_last, bus.cap_mask,
                  bus.done, bus.err_timeout});
  endfunction

  // Handshake happens at the next posedge; inputs only move just after posedges.
  always @(negedge clk) begin
    if (!rst && bus.res_valid && bus.res_ready) begin
      n_beats++;
      if (sb.size() == 0) begin
        check("sb_underflow", sb.size(), 1);
      end else begin
        beat_t e;
        e = sb.pop_front();
        check("res_data", int'(bus.res_data), e.data);
        check("res_idx", int'(bus.res_idx), e.idx);
        check("res_last", int'(bus.res_last), e.last);
      end
    end
  end

  task automatic run_op01(input logic stall);
    send_cmd(2'b01, 3'd2);
    check("t3_start_vp", int'(bus.start_valid_pipeline), 1);
    check("t3_mode", int'(bus.mode), 2);
    tick();                                   // T+2
    tick();                                   // T+3
    bus.busy = 1'b1;
    tick();
    set_lane(0, 25);
    push_exp(25, 0, 0);
    tick();
    set_lane(1, -7);
    push_exp(-7, 1, 1);
    if (stall) bus.res_ready = 1'b0;
    tick();
    bus.busy = 1'b0;
    if (stall) begin
      int n = 0;
      while (!bus.res_valid && n < 10) begin
        tick();
        n++;
      end
      for (int k = 0; k < 5; k++) begin
        check("stall_valid", int'(bus.res_valid), 1);
        check("stall_data", int'(bus.res_data), 25);
        check("stall_idx", int'(bus.res_idx), 0);
        tick();
      end
      bus.res_ready = 1'b1;
    end
    wait_done("t3_done", 30);
    check("t3_cap_mask", int'(bus.cap_mask), 3);
    check("t3_sb_empty", sb.size(), 0);
    check("t3_err", int'(bus.err_timeout), 0);
    bus.valid_out = '0;
    tick();
    tick();
  endtask

  initial begin
    int beats0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_mode  = '0;
    bus.busy      = 1'b0;
    bus.acc_in    = '0;
    bus.valid_out = '0;
    bus.res_ready = 1'b1;

    // Reset state
    repeat (3) tick();
    check("rst_outs", outs_or(), 0);
    rst = 1'b0;
    tick();
    check("rst_cmd_ready", int'(bus.cmd_ready), 1);

    // Weight load, busy never rises
    beats0 = n_beats;
    send_cmd(2'b00, 3'd1);
    check("t2_start_w", int'(bus.start_weight), 1);
    check("t2_start_vp", int'(bus.start_valid_pipeline), 0);
    check("t2_mode", int'(bus.mode), 1);
    check("t2_cmd_ready", int'(bus.cmd_ready), 0);
    tick();
    check("t2_start_w_off", int'(bus.start_weight), 0);
    repeat (BUSY_WAIT) tick();
    check("t2_done_early", int'(bus.done), 0);
    tick();
    check("t2_done", int'(bus.done), 1);
    check("t2_err", int'(bus.err_timeout), 0);
    check("t2_no_beats", n_beats - beats0, 0);
    tick();
    check("t2_done_off", int'(bus.done), 0);
    check("t2_mode_hold", int'(bus.mode), 1);

    // Valid pipeline with two lanes, then the same with a stalled consumer
    run_op01(1'b0);
    run_op01(1'b1);

    // Layering with busy stuck high
    send_cmd(2'b10, 3'd5);
    check("t5_start_l", int'(bus.start_layering), 1);
    bus.busy = 1'b1;
    tick();                                   // T+2
    set_lane(0, 42);
    push_exp(42, 0, 1);
    repeat (TIMEOUT) tick();                  // T+TIMEOUT+2
    check("t5_err_early", int'(bus.err_timeout), 0);
    tick();
    check("t5_err", int'(bus.err_timeout), 1);
    wait_done("t5_done", 30);
    check("t5_sb_empty", sb.size(), 0);
    check("t5_err_sticky", int'(bus.err_timeout), 1);
    bus.valid_out = '0;
    tick();
    tick();

    // Simultaneous edges and a repeated edge on lane 2
    send_cmd(2'b10, 3'd6);
    check("t6_err_cleared", int'(bus.err_timeout), 0);
    check("t6_cap_cleared", int'(bus.cap_mask), 0);
    bus.busy = 1'b1;
    tick();
    tick();                                   // T+3, RUN
    set_lane(2, 100);
    set_lane(3, 200);
    tick();
    bus.valid_out[2] = 1'b0;
    tick();
    set_lane(2, 150);
    push_exp(150, 2, 0);
    push_exp(200, 3, 1);
    tick();
    bus.busy = 1'b0;
    wait_done("t6_done", 30);
    check("t6_cap_mask", int'(bus.cap_mask), 12);
    check("t6_sb_empty", sb.size(), 0);
    bus.valid_out = '0;
    tick();

    // Clear all
    send_cmd(2'b11, 3'd0);
    check("t7_clear", int'(bus.clear_all), 1);
    check("t7_start_l", int'(bus.start_layering), 0);
    check("t7_cap_mask", int'(bus.cap_mask), 0);
    tick();
    check("t7_clear_off", int'(bus.clear_all), 0);
    check("t7_done", int'(bus.done), 1);
    tick();
    check("t7_done_off", int'(bus.done), 0);

    // Reset in RUN with busy high
    beats0 = n_beats;
    send_cmd(2'b01, 3'd3);
    bus.busy = 1'b1;
    tick();
    tick();
    set_lane(0, 55);
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("t8_rst_outs", outs_or(), 0);
    tick();
    check("t8_rst_outs_next", outs_or(), 0);
    bus.busy      = 1'b0;
    bus.valid_out = '0;
    rst = 1'b0;
    tick();
    check("t8_cmd_ready", int'(bus.cmd_ready), 1);
    repeat (20) tick();
    check("t8_no_beats", n_beats - beats0, 0);
    check("t8_idle_ready", int'(bus.cmd_ready), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
